// File: rtl/iterative_divider_pkg.sv
// Shared constants and FSM encoding for the iterative restoring divider.
// The step width, the iteration count and the result for a zero divisor are defined here.
package iterative_divider_pkg;

   localparam int WIDTH      = 16;
   localparam int ITERATIONS = 16;
   localparam int CNT_W      = $clog2(ITERATIONS);

   localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      DONE
   } state_t;

endpackage

// File: rtl/iterative_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step
   import iterative_divider_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0] shifted;
   logic [W:0] diff;

   // rem_in < divisor holds, so |shifted - divisor| < 2^W and diff[W] is the sign.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {1'b0, divisor};
      q_bit   = ~diff[W];
      rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
   end

endmodule

// File: rtl/iterative_divider.sv
// Unsigned 16-bit iterative restoring divider: one quotient bit per cycle,
// fixed 16-cycle latency, a zero divisor answers in a single cycle.
module iterative_divider
   import iterative_divider_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic [WIDTH-1:0] quo_q,   quo_d;
   logic [WIDTH-1:0] div_q,   div_d;
   logic             dz_q,    dz_d;

   logic [WIDTH-1:0] step_rem;
   logic             step_bit;

   // quo_q doubles as the dividend shift register: its MSB feeds each step.
   div_step #(.W(WIDTH)) u_step (
      .rem_in  (rem_q),
      .bit_in  (quo_q[WIDTH-1]),
      .divisor (div_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      dz_d    = dz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quo_d   = DIV0_QUOTIENT;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = dividend;
                  div_d   = divisor;
                  rem_d   = '0;
                  cnt_d   = '0;
                  dz_d    = 1'b0;
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            rem_d = step_rem;
            quo_d = {quo_q[WIDTH-2:0], step_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy        = (state_q == DIVIDE);
   assign done        = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;

endmodule
